rx_frame_parser: RTL and testbench
==================================

# rx_frame_parser

Receive-side counterpart of the client's frame transmitter. It accepts Ethernet frames from the MAC's LocalLink RX interface and validates the destination MAC and EtherType. It decodes the one-byte message type and 16-bit length, then drives connection status plus a byte-stream payload port toward downstream consumers such as the display buffer. The block sits between the MAC RX FIFO and the client application logic.

## Interface
- LOCAL_MAC, 48'h00_0A_35_00_00_01, accepted destination MAC; 48'hFF_FF_FF_FF_FF_FF is also accepted
- ETHERTYPE, 16'h88B5, accepted EtherType
- clk_100  in  1  system clock; the only clock
- RESET_N  in  1  asynchronous, active-low reset
- rx_data  in  8  frame byte
- rx_sof  in  1  first byte of frame
- rx_eof  in  1  last byte of frame
- rx_src_rdy  in  1  rx_data is valid
- rx_dst_rdy  out  1  block can accept a byte; a beat is rx_src_rdy && rx_dst_rdy
- payload_data  out  8  payload byte
- payload_valid  out  1  payload_data is valid
- payload_last  out  1  last payload byte of the frame
- payload_ready  in  1  downstream accepts the byte
- connected  out  1  connection status
- frame_err  out  1  one-cycle error pulse
- frames_ok  out  16  count of good frames; wraps
- frames_dropped  out  16  count of dropped frames; wraps

## Operation
- Frame layout, in bytes:
  - 0–5: destination MAC
  - 6–11: source MAC
  - 12–13: EtherType, big-endian
  - 14: message type
  - 15–16: LEN, big-endian
  - 17 onward: payload
  - After the payload, any padding runs to eof.
- Message types:
  - 8'h01 CONNECT_ACK sets connected.
  - 8'h02 DISCONNECT clears connected.
  - 8'h10 DATA forwards LEN payload bytes.
  - Any other value goes to DROP.
- States and transitions:
  - IDLE: a beat with rx_sof goes to HDR. Beats without rx_sof are discarded.
  - HDR: a 4-bit byte counter checks bytes 0–13. A MAC or EtherType mismatch goes to DROP.
  - TYPE: latches the type. An unknown type goes to DROP.
  - LEN: captures 2 bytes. For DATA with LEN≠0, go to PAYLOAD. Otherwise go to PAD.
  - PAYLOAD: a 16-bit down-counter runs. The LEN-th byte is emitted with payload_last=1, then the FSM goes to PAD.
  - PAD: discards bytes until eof.
  - DROP: discards bytes until eof.
- End-of-frame outcome, evaluated on the eof beat:
  - From PAD: frames_ok+1. CONNECT_ACK or DISCONNECT take effect on connected.
  - From DROP: frames_dropped+1 and frame_err pulse.
  - eof in HDR, TYPE or LEN (runt frame): frames_dropped+1 and frame_err pulse.
  - eof in PAYLOAD before LEN bytes: that byte is emitted with payload_last=1, plus frames_dropped+1 and frame_err.
  - In every case the FSM returns to IDLE.
- An rx_sof beat in any non-IDLE state counts the open frame as dropped, pulses frame_err, and restarts parsing from byte 0 using that beat.
- A single-beat frame (rx_sof and rx_eof together) is a runt: dropped, with frame_err.

## Timing
- All outputs are registered.
- Reset values:
  - rx_dst_rdy = 0
  - payload_data, payload_valid, payload_last = 0
  - connected = 0
  - frame_err = 0
  - frames_ok, frames_dropped = 0
  - FSM in IDLE
- rx_dst_rdy is 1 from the first cycle after reset release, except in PAYLOAD when payload_valid && !payload_ready. The output register is a single stage; it is refilled in the same cycle it drains.
- Latency:
  - Payload byte: 1 cycle from accepted beat to payload_valid.
  - connected and counters: update 1 cycle after the eof beat.
  - frame_err: pulses for 1 cycle, 1 cycle after the error beat.
- payload_data and payload_last stay stable while payload_valid && !payload_ready.
- Reset mid-frame:
  - Everything clears immediately.
  - Bytes are ignored until the next rx_sof.
  - No payload_last is generated for the aborted frame.
- Counters wrap from 16'hFFFF to 0.

## Structure
- Shared package `fpga_client_pkg` holds:
  - message-type constants MSG_CONNECT_ACK, MSG_DISCONNECT, MSG_DATA
  - header offsets: HDR_LEN=14, TYPE_OFS=14, LEN_OFS=15
  - FSM state encoding
- One sub-module, `rx_out_reg`: the 8+1-bit payload output register with valid/ready and the rx_dst_rdy term.
- The parser FSM, counters and connected flag live in rx_frame_parser.

## Test plan
- Frame to LOCAL_MAC, type 8'h01, LEN 0, padded to 60 bytes with payload_ready=1 -> connected=1 one cycle after eof; frames_ok=1; no payload_valid.
- DATA frame with LEN=4 and payload A1 B2 C3 D4, payload_ready toggled 1/0 every cycle -> exactly 4 bytes delivered in order, last with payload_last=1; rx_dst_rdy drops while stalled; padding is discarded.
- Destination MAC 00_0A_35_00_00_02 and broadcast DISCONNECT -> first frame is dropped (frames_dropped=1, frame_err pulse); second clears connected and gives frames_ok+1.
- DATA frame with LEN=10 whose eof arrives after 3 payload bytes -> 3 bytes delivered, third with payload_last=1; frame_err pulse; frames_dropped+1.
- rx_sof arriving at byte 8 of a frame, followed by a valid CONNECT_ACK frame -> one drop plus frame_err, then connected=1.
- RESET_N asserted mid-payload and released with bytes still streaming -> all outputs return to 0; no bytes forwarded until the next rx_sof; the next valid frame parses correctly.

Source files
------------

// File: rtl/fpga_client_pkg.sv
// Shared constants, state encoding and payload bundle
// for the client-side frame receive path.
package fpga_client_pkg;

   localparam logic [47:0] DEF_LOCAL_MAC = 48'h00_0A_35_00_00_01;
   localparam logic [47:0] BCAST_MAC     = 48'hFF_FF_FF_FF_FF_FF;
   localparam logic [15:0] DEF_ETHERTYPE = 16'h88B5;

   localparam logic [7:0] MSG_CONNECT_ACK = 8'h01;
   localparam logic [7:0] MSG_DISCONNECT  = 8'h02;
   localparam logic [7:0] MSG_DATA        = 8'h10;

   localparam logic [3:0] HDR_LEN  = 4'd14;
   localparam logic [3:0] TYPE_OFS = 4'd14;
   localparam logic [3:0] LEN_OFS  = 4'd15;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_HDR     = 3'd1;
   localparam logic [2:0] S_TYPE    = 3'd2;
   localparam logic [2:0] S_LEN     = 3'd3;
   localparam logic [2:0] S_PAYLOAD = 3'd4;
   localparam logic [2:0] S_PAD     = 3'd5;
   localparam logic [2:0] S_DROP    = 3'd6;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } pay_t;

   // byte i of a MAC address, most significant byte first
   function automatic logic [7:0] mac_byte(input logic [47:0] m,
                                           input logic [2:0]  i);
      logic [47:0] t;
      t = m << {i, 3'b000};
      return t[47:40];
   endfunction

endpackage

// File: rtl/rx_out_reg.sv
// Single-stage payload output register with valid/ready
// and the upstream accept term.
import fpga_client_pkg::*;

module rx_out_reg (
   input  logic       clk_100,
   input  logic       RESET_N,
   input  logic       load,
   input  pay_t       din,
   input  logic       hold,
   input  logic       payload_ready,
   output logic [7:0] payload_data,
   output logic       payload_valid,
   output logic       payload_last,
   output logic       rx_dst_rdy
);

   pay_t q;
   logic valid_q;
   logic en_q;

   always_ff @(posedge clk_100 or negedge RESET_N) begin
      if (!RESET_N) begin
         q       <= '0;
         valid_q <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         en_q <= 1'b1;
         if (load) begin
            q       <= din;
            valid_q <= 1'b1;
         end else if (payload_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign payload_data  = q.data;
   assign payload_last  = q.last;
   assign payload_valid = valid_q;
   // a draining register may be refilled in the same cycle
   assign rx_dst_rdy = en_q & ~(hold & valid_q & ~payload_ready);

endmodule

// File: rtl/rx_frame_parser.sv
// LocalLink RX frame parser: checks MAC/EtherType, decodes
// type and LEN, tracks connection state, streams payload.
import fpga_client_pkg::*;

module rx_frame_parser #(
   parameter logic [47:0] LOCAL_MAC = DEF_LOCAL_MAC,
   parameter logic [15:0] ETHERTYPE = DEF_ETHERTYPE
) (
   input  logic        clk_100,
   input  logic        RESET_N,
   input  logic [7:0]  rx_data,
   input  logic        rx_sof,
   input  logic        rx_eof,
   input  logic        rx_src_rdy,
   output logic        rx_dst_rdy,
   output logic [7:0]  payload_data,
   output logic        payload_valid,
   output logic        payload_last,
   input  logic        payload_ready,
   output logic        connected,
   output logic        frame_err,
   output logic [15:0] frames_ok,
   output logic [15:0] frames_dropped
);

   logic [2:0]  state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic        lok, lok_n, bok, bok_n;
   logic [7:0]  mtype, mtype_n;
   logic [15:0] rem, rem_n;
   logic        beat, load, ok_inc, set_c, clr_c;
   logic [1:0]  drop_n;
   pay_t        din;

   assign beat = rx_src_rdy & rx_dst_rdy;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      lok_n   = lok;
      bok_n   = bok;
      mtype_n = mtype;
      rem_n   = rem;
      load    = 1'b0;
      din     = '{data: rx_data, last: 1'b0};
      ok_inc  = 1'b0;
      drop_n  = 2'd0;
      set_c   = 1'b0;
      clr_c   = 1'b0;
      if (beat && rx_sof) begin
         // a new sof always restarts parsing at byte 0
         drop_n  = (state != S_IDLE) ? 2'd1 : 2'd0;
         lok_n   = rx_data == mac_byte(LOCAL_MAC, 3'd0);
         bok_n   = rx_data == mac_byte(BCAST_MAC, 3'd0);
         cnt_n   = 4'd1;
         state_n = (lok_n | bok_n) ? S_HDR : S_DROP;
         if (rx_eof) begin
            drop_n  = drop_n + 2'd1;
            state_n = S_IDLE;
         end
      end else if (beat) begin
         unique case (state)
            S_IDLE: ;
            S_HDR: begin
               cnt_n = cnt + 4'd1;
               if (cnt < 4'd6) begin
                  lok_n = lok & (rx_data == mac_byte(LOCAL_MAC, cnt[2:0]));
                  bok_n = bok & (rx_data == mac_byte(BCAST_MAC, cnt[2:0]));
                  if (!lok_n && !bok_n)
                     state_n = S_DROP;
               end else if (cnt == HDR_LEN - 4'd2) begin
                  if (rx_data != ETHERTYPE[15:8])
                     state_n = S_DROP;
               end else if (cnt == TYPE_OFS - 4'd1) begin
                  state_n = (rx_data == ETHERTYPE[7:0]) ? S_TYPE : S_DROP;
               end
            end
            S_TYPE: begin
               cnt_n   = cnt + 4'd1;
               mtype_n = rx_data;
               state_n = (rx_data == MSG_CONNECT_ACK ||
                          rx_data == MSG_DISCONNECT ||
                          rx_data == MSG_DATA) ? S_LEN : S_DROP;
            end
            S_LEN: begin
               cnt_n = cnt + 4'd1;
               if (cnt == LEN_OFS) begin
                  rem_n[15:8] = rx_data;
               end else begin
                  rem_n[7:0] = rx_data;
                  state_n = (mtype == MSG_DATA &&
                             {rem[15:8], rx_data} != 16'd0) ? S_PAYLOAD : S_PAD;
               end
            end
            S_PAYLOAD: begin
               load     = 1'b1;
               rem_n    = rem - 16'd1;
               din.last = (rem == 16'd1) | rx_eof;
               if (rem == 16'd1)
                  state_n = S_PAD;
               if (rx_eof) begin
                  ok_inc = rem == 16'd1;
                  drop_n = (rem == 16'd1) ? 2'd0 : 2'd1;
               end
            end
            S_PAD: begin
               if (rx_eof) begin
                  ok_inc = 1'b1;
                  set_c  = mtype == MSG_CONNECT_ACK;
                  clr_c  = mtype == MSG_DISCONNECT;
               end
            end
            S_DROP: begin
               if (rx_eof)
                  drop_n = 2'd1;
            end
            default: state_n = S_IDLE;
         endcase
         // header-stage eof is a runt frame
         if (rx_eof && (state == S_HDR || state == S_TYPE || state == S_LEN))
            drop_n = 2'd1;
         if (rx_eof)
            state_n = S_IDLE;
      end
   end

   always_ff @(posedge clk_100 or negedge RESET_N) begin
      if (!RESET_N) begin
         state          <= S_IDLE;
         cnt            <= 4'd0;
         lok            <= 1'b0;
         bok            <= 1'b0;
         mtype          <= 8'd0;
         rem            <= 16'd0;
         connected      <= 1'b0;
         frame_err      <= 1'b0;
         frames_ok      <= 16'd0;
         frames_dropped <= 16'd0;
      end else begin
         state          <= state_n;
         cnt            <= cnt_n;
         lok            <= lok_n;
         bok            <= bok_n;
         mtype          <= mtype_n;
         rem            <= rem_n;
         frame_err      <= drop_n != 2'd0;
         frames_ok      <= frames_ok + {15'd0, ok_inc};
         frames_dropped <= frames_dropped + {14'd0, drop_n};
         if (set_c)
            connected <= 1'b1;
         else if (clr_c)
            connected <= 1'b0;
      end
   end

   rx_out_reg u_out (
      .clk_100       (clk_100),
      .RESET_N       (RESET_N),
      .load          (load),
      .din           (din),
      .hold          (state == S_PAYLOAD),
      .payload_ready (payload_ready),
      .payload_data  (payload_data),
      .payload_valid (payload_valid),
      .payload_last  (payload_last),
      .rx_dst_rdy    (rx_dst_rdy)
   );

endmodule

// File: tb/tb_rx_frame_parser.sv
// Directed bench for rx_frame_parser: connect/disconnect,
// data with backpressure, drops, runts and mid-frame reset.
module tb_rx_frame_parser;

   logic        clk_100 = 1'b0;
   logic        RESET_N;
   logic [7:0]  rx_data;
   logic        rx_sof, rx_eof, rx_src_rdy, rx_dst_rdy;
   logic [7:0]  payload_data;
   logic        payload_valid, payload_last, payload_ready;
   logic        connected, frame_err;
   logic [15:0] frames_ok, frames_dropped;

   rx_frame_parser dut (
      .clk_100        (clk_100),
      .RESET_N        (RESET_N),
      .rx_data        (rx_data),
      .rx_sof         (rx_sof),
      .rx_eof         (rx_eof),
      .rx_src_rdy     (rx_src_rdy),
      .rx_dst_rdy     (rx_dst_rdy),
      .payload_data   (payload_data),
      .payload_valid  (payload_valid),
      .payload_last   (payload_last),
      .payload_ready  (payload_ready),
      .connected      (connected),
      .frame_err      (frame_err),
      .frames_ok      (frames_ok),
      .frames_dropped (frames_dropped)
   );

   always #5 clk_100 = ~clk_100;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [7:0] pq[$];
   logic       lq[$];
   int         errs = 0;
   int         stalls = 0;
   logic       tog = 1'b0;

   always @(posedge clk_100) begin
      if (RESET_N === 1'b1) begin
         if (payload_valid && payload_ready) begin
            pq.push_back(payload_data);
            lq.push_back(payload_last);
         end
         if (frame_err)
            errs++;
         if (rx_src_rdy && !rx_dst_rdy)
            stalls++;
      end
   end

   logic [7:0] fq[$];

   task automatic build(input logic [47:0] dst, input logic [7:0] t,
                        input logic [15:0] len);
      fq.delete();
      for (int i = 0; i < 6; i++) fq.push_back(dst[47-8*i -: 8]);
      for (int i = 0; i < 6; i++) fq.push_back(8'h20 + 8'(i));
      fq.push_back(8'h88);
      fq.push_back(8'hB5);
      fq.push_back(t);
      fq.push_back(len[15:8]);
      fq.push_back(len[7:0]);
   endtask

   task automatic pad(input int n);
      while (fq.size() < n) fq.push_back(8'h00);
   endtask

   // starts and ends at a falling edge
   task automatic beat(input logic [7:0] d, input logic s, input logic e);
      int n;
      logic acc;
      n = 0;
      rx_data = d; rx_sof = s; rx_eof = e; rx_src_rdy = 1'b1;
      forever begin
         #4;
         acc = rx_dst_rdy;
         @(negedge clk_100);
         if (tog) payload_ready = ~payload_ready;
         if (acc) break;
         n++;
         if (n > 100) begin
            check("dst_rdy_timeout", rx_dst_rdy, 1);
            break;
         end
      end
      rx_src_rdy = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
   endtask

   task automatic send(input int from, input int to, input logic eof_end);
      for (int i = from; i <= to; i++)
         beat(fq[i], i == 0, eof_end && i == to);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk_100);
         if (tog) payload_ready = ~payload_ready;
      end
   endtask

   localparam logic [47:0] MAC_OK  = 48'h00_0A_35_00_00_01;
   localparam logic [47:0] MAC_BAD = 48'h00_0A_35_00_00_02;
   localparam logic [47:0] MAC_BC  = 48'hFF_FF_FF_FF_FF_FF;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int p0, s0, e0;
      logic [7:0] t2d[4];
      t2d = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      RESET_N = 1'b0;
      rx_data = 8'h00; rx_sof = 1'b0; rx_eof = 1'b0; rx_src_rdy = 1'b0;
      payload_ready = 1'b1;
      repeat (3) @(negedge clk_100);
      check("rst_dst_rdy", rx_dst_rdy, 0);
      check("rst_valid", payload_valid, 0);
      check("rst_conn", connected, 0);
      check("rst_err", frame_err, 0);
      check("rst_ok", frames_ok, 0);
      check("rst_drop", frames_dropped, 0);
      RESET_N = 1'b1;
      @(negedge clk_100);
      check("rdy_after_rst", rx_dst_rdy, 1);

      // CONNECT_ACK, LEN 0, padded to 60
      p0 = pq.size();
      build(MAC_OK, 8'h01, 16'd0);
      pad(60);
      send(0, 58, 1'b0);
      check("t1_conn_pre", connected, 0);
      beat(fq[59], 1'b0, 1'b1);
      check("t1_conn", connected, 1);
      check("t1_ok", frames_ok, 1);
      check("t1_drop", frames_dropped, 0);
      idle(2);
      check("t1_nopay", pq.size() - p0, 0);

      // DATA LEN 4 with toggling payload_ready
      p0 = pq.size();
      s0 = stalls;
      build(MAC_OK, 8'h10, 16'd4);
      for (int i = 0; i < 4; i++) fq.push_back(t2d[i]);
      pad(60);
      tog = 1'b1;
      send(0, 59, 1'b1);
      tog = 1'b0;
      payload_ready = 1'b1;
      idle(4);
      check("t2_count", pq.size() - p0, 4);
      for (int i = 0; i < 4; i++)
         check($sformatf("t2_byte%0d", i), pq[p0+i], t2d[i]);
      check("t2_last", {lq[p0], lq[p0+1], lq[p0+2], lq[p0+3]}, 4'b0001);
      check("t2_stalled", (stalls - s0) != 0, 1);
      check("t2_ok", frames_ok, 2);

      // wrong MAC dropped, broadcast DISCONNECT accepted
      e0 = errs;
      build(MAC_BAD, 8'h02, 16'd0);
      pad(60);
      send(0, 59, 1'b1);
      check("t3_err", frame_err, 1);
      check("t3_drop", frames_dropped, 1);
      check("t3_conn_kept", connected, 1);
      build(MAC_BC, 8'h02, 16'd0);
      pad(60);
      send(0, 59, 1'b1);
      check("t3_conn", connected, 0);
      check("t3_ok", frames_ok, 3);
      check("t3_err_clr", frame_err, 0);
      idle(2);
      check("t3_pulses", errs - e0, 1);

      // LEN 10 truncated after 3 payload bytes
      p0 = pq.size();
      build(MAC_OK, 8'h10, 16'd10);
      fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33);
      send(0, 19, 1'b1);
      check("t4_err", frame_err, 1);
      check("t4_drop", frames_dropped, 2);
      idle(3);
      check("t4_count", pq.size() - p0, 3);
      check("t4_bytes", {pq[p0], pq[p0+1], pq[p0+2]}, 24'h112233);
      check("t4_last", {lq[p0], lq[p0+1], lq[p0+2]}, 3'b001);
      check("t4_ok", frames_ok, 3);

      // sof at byte 8 then a full CONNECT_ACK
      e0 = errs;
      build(MAC_OK, 8'h01, 16'd0);
      pad(60);
      send(0, 7, 1'b0);
      send(0, 59, 1'b1);
      check("t5_conn", connected, 1);
      check("t5_drop", frames_dropped, 3);
      check("t5_ok", frames_ok, 4);
      idle(2);
      check("t5_pulses", errs - e0, 1);

      // reset in the middle of a payload
      build(MAC_OK, 8'h10, 16'd10);
      for (int i = 0; i < 10; i++) fq.push_back(8'h41 + 8'(i));
      send(0, 20, 1'b0);
      RESET_N = 1'b0;
      #1;
      check("t6_valid", payload_valid, 0);
      check("t6_last", payload_last, 0);
      check("t6_data", payload_data, 0);
      check("t6_conn", connected, 0);
      check("t6_ok", frames_ok, 0);
      check("t6_drop", frames_dropped, 0);
      check("t6_rdy", rx_dst_rdy, 0);
      p0 = pq.size();
      e0 = errs;
      for (int i = 21; i < 27; i++) begin
         rx_data = fq[i]; rx_sof = 1'b0; rx_eof = (i == 26); rx_src_rdy = 1'b1;
         if (i == 23) RESET_N = 1'b1;
         @(negedge clk_100);
      end
      rx_src_rdy = 1'b0; rx_eof = 1'b0;
      idle(3);
      check("t6_noflow", pq.size() - p0, 0);
      check("t6_noerr", errs - e0, 0);
      check("t6_ok_idle", frames_ok, 0);
      check("t6_drop_idle", frames_dropped, 0);
      build(MAC_OK, 8'h10, 16'd2);
      fq.push_back(8'h55); fq.push_back(8'h66);
      pad(24);
      send(0, 23, 1'b1);
      idle(3);
      check("t6_count", pq.size() - p0, 2);
      check("t6_bytes", {pq[p0], pq[p0+1]}, 16'h5566);
      check("t6_lastf", {lq[p0], lq[p0+1]}, 2'b01);
      check("t6_ok_after", frames_ok, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
